// File: rtl/reg_dst_pipe.sv
// reg_dst_pipe
//   Picks a destination register index from the instruction fields according to
//   RegDst. It then carries that index through a STAGES-deep {valid, addr} delay
//   line that ends in a write-back strobe. While an entry is in flight it can
//   flag read-after-write hazards for two source addresses.
//
// Ports
//   clk, reset              clock; asynchronous active-high reset
//   RegDst                  000 rt, 001 rd, 010 REG_RA, 011 REG_SP, 100 rs, others illegal
//   in_rt, in_rd, in_rs     candidate destination fields
//   issue, stall, flush     enter new entry / freeze pipe / drop all in-flight entries
//   qa, qb                  source addresses checked against pending destinations
//   ready                   ~stall
//   wb_addr, wb_valid       write-back destination and strobe (last stage)
//   hazard_a, hazard_b      qa/qb matches a valid in-flight destination
//   pending_cnt             number of valid in-flight entries
//   sel_err                 sticky: an illegal RegDst was issued while not stalled
module reg_dst_pipe #(
  parameter int ADDR_W = 5,
  parameter int STAGES = 3,
  parameter int REG_RA = 31,
  parameter int REG_SP = 29
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [2:0]                   RegDst,
  input  logic [ADDR_W-1:0]            in_rt,
  input  logic [ADDR_W-1:0]            in_rd,
  input  logic [ADDR_W-1:0]            in_rs,
  input  logic                         issue,
  input  logic                         stall,
  input  logic                         flush,
  input  logic [ADDR_W-1:0]            qa,
  input  logic [ADDR_W-1:0]            qb,
  output logic                         ready,
  output logic [ADDR_W-1:0]            wb_addr,
  output logic                         wb_valid,
  output logic                         hazard_a,
  output logic                         hazard_b,
  output logic [$clog2(STAGES+1)-1:0]  pending_cnt,
  output logic                         sel_err
);

  localparam int CNT_W = $clog2(STAGES + 1);

  typedef enum logic [2:0] {
    SEL_RT = 3'b000,
    SEL_RD = 3'b001,
    SEL_RA = 3'b010,
    SEL_SP = 3'b011,
    SEL_RS = 3'b100
  } sel_e;

  logic [STAGES-1:0]             valid_q, valid_d;
  logic [STAGES-1:0][ADDR_W-1:0] addr_q, addr_d;
  logic [CNT_W-1:0]              cnt_q, cnt_d;
  logic                          sel_err_q, sel_err_d;

  logic [ADDR_W-1:0]             sel_addr;
  logic                          sel_legal;

  // Destination select
  always_comb begin
    sel_addr  = '0;
    sel_legal = 1'b1;
    case (RegDst)
      SEL_RT:  sel_addr = in_rt;
      SEL_RD:  sel_addr = in_rd;
      SEL_RA:  sel_addr = ADDR_W'(REG_RA);
      SEL_SP:  sel_addr = ADDR_W'(REG_SP);
      SEL_RS:  sel_addr = in_rs;
      default: sel_legal = 1'b0;
    endcase
  end

  // Pipe next state. Flush wins over stall; address fields are left alone on
  // flush because nothing reads them while valid is low.
  always_comb begin
    valid_d = valid_q;
    addr_d  = addr_q;
    if (flush) begin
      valid_d = '0;
    end else if (!stall) begin
      // Register 0 is never a real destination, so it never occupies a slot.
      valid_d[0] = issue && sel_legal && (sel_addr != '0);
      addr_d[0]  = sel_addr;
      for (int k = 1; k < STAGES; k++) begin
        valid_d[k] = valid_q[k-1];
        addr_d[k]  = addr_q[k-1];
      end
    end
  end

  // The count is registered alongside the stages so it always matches them.
  always_comb begin
    cnt_d = '0;
    for (int i = 0; i < STAGES; i++) begin
      cnt_d = cnt_d + CNT_W'(valid_d[i]);
    end
  end

  assign sel_err_d = sel_err_q | (issue & ~stall & ~sel_legal);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q   <= '0;
      addr_q    <= '0;
      cnt_q     <= '0;
      sel_err_q <= 1'b0;
    end else begin
      valid_q   <= valid_d;
      addr_q    <= addr_d;
      cnt_q     <= cnt_d;
      sel_err_q <= sel_err_d;
    end
  end

  // Hazard lookup is driven by stage state only. An entry that is being issued
  // in this cycle is not visible until the next cycle.
  always_comb begin
    hazard_a = 1'b0;
    hazard_b = 1'b0;
    for (int i = 0; i < STAGES; i++) begin
      if (valid_q[i] && (addr_q[i] == qa) && (qa != '0)) hazard_a = 1'b1;
      if (valid_q[i] && (addr_q[i] == qb) && (qb != '0)) hazard_b = 1'b1;
    end
  end

  assign ready       = ~stall;
  assign wb_addr     = addr_q[STAGES-1];
  assign wb_valid    = valid_q[STAGES-1] & ~stall;
  assign pending_cnt = cnt_q;
  assign sel_err     = sel_err_q;

endmodule
